// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : knn_pkg
// Description : Training-sample BRAM geometry, packed-word field layout and
//               loader state encoding, shared by the train loader (writer) and
//               the distance engine (reader).
// Revision    : 1.0 - initial release
// ============================================================================
package knn_pkg;

    // BRAM geometry: one word per training sample
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 18;

    // Packed sample word layout
    localparam int X_MSB   = 17;
    localparam int X_LSB   = 10;
    localparam int Y_MSB   = 9;
    localparam int Y_LSB   = 2;
    localparam int CLS_BIT = 1;
    localparam int VLD_BIT = 0;

    // Loader sequencing: three byte-collection states, a one-cycle write
    // bubble and a one-cycle completion state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_X = 3'd1,
        ST_GET_Y = 3'd2,
        ST_GET_C = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/knn_train_loader.sv
`default_nettype none
// ============================================================================
// Module      : knn_train_loader
// Description : Writer side of the training-sample BRAM. Collects x, y and
//               class bytes from a valid/ready stream, packs each sample into
//               one word and writes words to addresses 0..DEPTH-1, then
//               reports completion so the engine only runs on a full set.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_train_loader #(
    parameter int DEPTH  = knn_pkg::DEPTH,
    parameter int ADDR_W = knn_pkg::ADDR_W,
    parameter int DATA_W = knn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              loaded,
    output logic              load_done,
    output logic              fmt_err,
    output logic [ADDR_W:0]   samples_written
);
    import knn_pkg::*;

    load_state_t       state;
    load_state_t       state_nxt;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] packed_word;
    logic              accept;
    logic              last_word;
    logic              start_load;
    logic              class_take;

    // A byte is consumed whenever the stream offers one and we are collecting
    assign accept     = in_valid && in_ready;

    // The word in flight is the final one of the set
    assign last_word  = (count[ADDR_W-1:0] == ADDR_W'(DEPTH - 1));

    // load_start is only honoured from IDLE; it outranks a same-cycle abort
    assign start_load = (state == ST_IDLE) && load_start;

    // Class byte accepted and not cancelled: this sample will be written
    assign class_take = (state == ST_GET_C) && accept && !abort;

    // Assemble the BRAM word from the latched coordinates and the live class byte
    always_comb begin
        packed_word          = '0;
        packed_word[X_MSB:X_LSB] = x_q;
        packed_word[Y_MSB:Y_LSB] = y_q;
        packed_word[CLS_BIT] = in_data[0];
        packed_word[VLD_BIT] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; abort returns to IDLE from any
    // collecting or writing state and suppresses the write strobe
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        load_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (load_start) begin
                    state_nxt = ST_GET_X;
                end
            end
            ST_GET_X: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    state_nxt = ST_GET_Y;
                end
            end
            ST_GET_Y: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    state_nxt = ST_GET_C;
                end
            end
            ST_GET_C: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en = !abort;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_word) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_GET_X;
                end
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Coordinate latches: x and y are held until the class byte completes the sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= 8'd0;
            y_q <= 8'd0;
        end else begin
            if ((state == ST_GET_X) && accept) begin
                x_q <= in_data;
            end
            if ((state == ST_GET_Y) && accept) begin
                y_q <= in_data;
            end
        end
    end

    // Write port registers: loaded once per sample so they hold between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (class_take) begin
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= packed_word;
        end
    end

    // Word counter doubles as the write address; it only advances on a real write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start_load) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + (ADDR_W + 1)'(1);
        end
    end

    // Completion level: set on the final write, cleared when a new load begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loaded <= 1'b0;
        end else if (start_load) begin
            loaded <= 1'b0;
        end else if (wr_en && last_word) begin
            loaded <= 1'b1;
        end
    end

    // Sticky format error: class bytes must be 0x00 or 0x01; any consumed
    // class byte counts, even one whose sample is cancelled by abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fmt_err <= 1'b0;
        end else if (start_load) begin
            fmt_err <= 1'b0;
        end else if ((state == ST_GET_C) && accept && (in_data[7:1] != 7'd0)) begin
            fmt_err <= 1'b1;
        end
    end

    assign samples_written = count;

endmodule
`default_nettype wire

// File: tb/tb_knn_train_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_train_loader
// Description : Self-checking bench for knn_train_loader. A sample-level
//               reference model tracks the load and is compared against the
//               DUT every cycle; directed scenarios pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_train_loader;
    import knn_pkg::*;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              load_start = 1'b0;
    logic              abort      = 1'b0;
    logic [7:0]        in_data    = 8'd0;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              loaded;
    logic              load_done;
    logic              fmt_err;
    logic [ADDR_W:0]   samples_written;

    knn_train_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_start      (load_start),
        .abort           (abort),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .loaded          (loaded),
        .load_done       (load_done),
        .fmt_err         (fmt_err),
        .samples_written (samples_written)
    );

    always #5 clk = ~clk;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a load is a sequence of 3-byte samples; each
    // completed sample produces one write slot the cycle after its class
    // byte, and the DEPTH-th write is followed by one completion cycle.
    // ------------------------------------------------------------------
    bit          m_active = 1'b0;   // a load is in progress (busy)
    bit          m_wpend  = 1'b0;   // a completed sample occupies the write slot
    bit          m_done   = 1'b0;   // completion cycle
    bit          m_loaded = 1'b0;
    bit          m_fmt    = 1'b0;
    int          m_nbytes = 0;      // bytes of the current sample received
    int          m_count  = 0;
    logic [7:0]  m_b0     = 8'd0;
    logic [7:0]  m_b1     = 8'd0;
    int          m_waddr  = 0;
    logic [17:0] m_wdata  = 18'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_wpend = 0; m_done = 0; m_loaded = 0; m_fmt = 0;
            m_nbytes = 0; m_count = 0; m_waddr = 0; m_wdata = 18'd0;
        end else if (!m_active) begin
            if (load_start) begin
                m_active = 1; m_nbytes = 0; m_count = 0; m_loaded = 0; m_fmt = 0;
            end
        end else if (m_done) begin
            m_done   = 0;
            m_active = 0;
        end else if (m_wpend) begin
            m_wpend = 0;
            if (abort) begin
                m_active = 0;
            end else begin
                m_count++;
                if (m_count == DEPTH) begin
                    m_done   = 1;
                    m_loaded = 1;
                end
            end
        end else begin
            if (in_valid) begin
                if (m_nbytes == 0) begin
                    m_b0 = in_data;
                end else if (m_nbytes == 1) begin
                    m_b1 = in_data;
                end else begin
                    if (in_data > 8'd1) m_fmt = 1;
                    if (!abort) begin
                        m_waddr = m_count;
                        m_wdata = {m_b0, m_b1, in_data[0], 1'b1};
                        m_wpend = 1;
                    end
                end
                m_nbytes = (m_nbytes + 1) % 3;
            end
            if (abort) begin
                m_active = 0;
                m_nbytes = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",        in_ready,        32'(m_active && !m_wpend && !m_done));
            chk("wr_en",           wr_en,           32'(m_wpend && !abort));
            chk("busy",            busy,            32'(m_active));
            chk("load_done",       load_done,       32'(m_done));
            chk("loaded",          loaded,          32'(m_loaded));
            chk("fmt_err",         fmt_err,         32'(m_fmt));
            chk("samples_written", samples_written, 32'(m_count));
            chk("wr_addr",         wr_addr,         32'(m_waddr));
            chk("wr_data",         wr_data,         32'(m_wdata));
        end
    end

    // BRAM image written by the DUT plus write/completion timing
    logic [17:0] bram [DEPTH];
    int          nwr         = 0;
    int          wr_cyc[$];
    int          done_cnt    = 0;
    int          done_cyc    = 0;
    int          rdy_in_wr   = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) begin
                bram[wr_addr] = wr_data;
                nwr++;
                wr_cyc.push_back(cyc);
            end
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (wr_en && in_ready) rdy_in_wr++;
        end
    end

    function automatic logic [17:0] exp_word(input int i);
        logic [7:0] xi;
        logic [7:0] yi;
        xi = 8'(i);
        yi = 8'(0 - i);
        return {xi, yi, xi[0], 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Offer one byte until it is accepted; optionally raise abort exactly
    // in the handshake cycle
    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit ab);
        bit hs;
        int guard = 0;
        forever begin
            in_data  = b;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort    = ab && in_valid && in_ready;
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            abort = 1'b0;
            if (hs) break;
            guard++;
            if (guard > 40) begin
                tests++;
                fails++;
                $display("FAIL handshake_timeout: byte %0h not accepted in 40 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c, input bit rnd);
        send_byte(x, rnd, 1'b0);
        send_byte(y, rnd, 1'b0);
        send_byte(c, rnd, 1'b0);
    endtask

    task automatic full_load(input bit rnd);
        for (int i = 0; i < DEPTH; i++) bram[i] = 18'd0;
        nwr = 0; wr_cyc.delete(); done_cnt = 0; rdy_in_wr = 0;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_sample(8'(i), 8'(0 - i), 8'(i % 2), rnd);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("full_nwr",      nwr,             DEPTH);
        chk("full_done_cnt", done_cnt,        1);
        chk("full_loaded",   loaded,          1);
        chk("full_busy",     busy,            0);
        chk("full_samples",  samples_written, DEPTH);
        chk("full_in_ready_during_write", rdy_in_wr, 0);
        if (wr_cyc.size() == DEPTH) begin
            chk("full_done_after_last", done_cyc, wr_cyc[DEPTH-1] + 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("img[%0d]", i), bram[i], exp_word(i));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy",     busy,     0);
        chk("rst_wr_addr",  wr_addr,  0);
        chk("rst_wr_data",  wr_data,  0);
        chk("rst_samples",  samples_written, 0);
        reset = 1'b1;
        tick();

        // First sample: x=5, y=-5, class=1
        pulse_start();
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'hFB, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t2_wr_en",   wr_en,   1);
        chk("t2_wr_addr", wr_addr, 0);
        chk("t2_wr_data", wr_data, 32'h017EF);
        tick();
        chk("t2_samples", samples_written, 1);

        // Asynchronous reset while waiting for y
        send_byte(8'h11, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy",     busy,     0);
        chk("arst_samples",  samples_written, 0);
        chk("arst_wr_data",  wr_data,  0);
        chk("arst_wr_addr",  wr_addr,  0);
        tick();
        reset = 1'b1;
        tick();

        // Full continuous load, then exact 4-cycle write spacing
        full_load(1'b0);
        for (int i = 1; i < wr_cyc.size(); i++) begin
            chk($sformatf("gap[%0d]", i), wr_cyc[i] - wr_cyc[i-1], 4);
        end

        // Same image with a randomly stalling stream
        full_load(1'b1);

        // Malformed class byte
        pulse_start();
        send_sample(8'd1, 8'd2, 8'h03, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("fmt_set",     fmt_err, 1);
        chk("fmt_wr_data", wr_data, 32'h0040B);
        send_sample(8'd3, 8'd4, 8'h00, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("fmt_sticky", fmt_err, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulse_start();
        chk("fmt_cleared", fmt_err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort coinciding with the 10th class byte
        nwr = 0;
        pulse_start();
        for (int i = 0; i < 9; i++) send_sample(8'(i), 8'(i + 1), 8'(i % 2), 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("abort_nwr",     nwr,             9);
        chk("abort_wr_en",   wr_en,           0);
        chk("abort_busy",    busy,            0);
        chk("abort_samples", samples_written, 9);
        chk("abort_loaded",  loaded,          0);
        tick();
        tick();
        pulse_start();
        send_sample(8'd7, 8'd7, 8'd0, 1'b0);
        in_valid = 1'b0;
        chk("restart_wr_en",   wr_en,   1);
        chk("restart_wr_addr", wr_addr, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Random traffic with sporadic starts and aborts
        for (int i = 0; i < 600; i++) begin
            load_start = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 29) == 0);
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            tick();
        end
        load_start = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/knn_train_loader.md
Name: knn_train_loader

Overview:
Writer side of the training-sample BRAM that the distance engine reads. Accepts a byte stream (x, y, class per sample, e.g. from the host UART receiver) over a valid/ready handshake and packs each sample into one 18-bit word. Writes the words sequentially to BRAM addresses 0..DEPTH-1 and reports completion, so the engine is only started on a fully loaded training set.

Parameters:
DEPTH, 64, number of training samples / BRAM words written per load
ADDR_W, 6, BRAM address width; must satisfy 2**ADDR_W >= DEPTH
DATA_W, 18, BRAM word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_start  in  1  single-cycle pulse; begins a new load at address 0
abort  in  1  synchronous; cancels a load in progress
in_data  in  8  stream byte (signed for x/y)
in_valid  in  1  in_data is valid
in_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  BRAM write strobe
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  DATA_W  packed word: [17:10]=x, [9:2]=y, [1]=class, [0]=entry-valid (always 1)
busy  out  1  load in progress
loaded  out  1  level; full set written, cleared by load_start or reset
load_done  out  1  one-cycle pulse when the final word is written
fmt_err  out  1  sticky; a class byte had bits [7:1] nonzero
samples_written  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; in_ready, wr_en, busy, loaded, load_done and fmt_err are 0; wr_addr, wr_data and samples_written are 0.
- States: IDLE, GET_X, GET_Y, GET_C, WRITE, DONE.
- A byte is accepted when in_valid && in_ready. in_ready=1 only in GET_X, GET_Y and GET_C, and it is registered from the state.
- IDLE: load_start -> GET_X. The same edge clears addr, samples_written, loaded and fmt_err. load_start in any other state is ignored.
- GET_X: on accept, latch x -> GET_Y. GET_Y: on accept, latch y -> GET_C. GET_C: on accept, latch class=in_data[0] and set fmt_err if in_data[7:1]!=0 -> WRITE. Without a handshake, the state holds.
- WRITE: lasts one cycle. wr_en=1, wr_addr=addr, wr_data={x,y,class,1'b1}. On the following edge addr and samples_written increment.
  - If addr==DEPTH-1: go to DONE.
  - Otherwise: go to GET_X.
- Latency: wr_en is asserted the cycle after the class-byte handshake. Throughput is at best 4 cycles per sample, with one bubble in WRITE.
- DONE: lasts one cycle. load_done=1 and loaded is set. Next state IDLE. loaded then holds until the next load_start or reset.
- busy=1 in GET_X through DONE inclusive.
- wr_en is 0 in every state except WRITE. wr_addr and wr_data hold their last values otherwise.
- abort in GET_X, GET_Y, GET_C or WRITE: go to IDLE next edge with no write in that cycle (wr_en is forced 0).
  - loaded stays 0.
  - Words already written remain in the BRAM.
  - samples_written holds the partial count.
- abort in IDLE or DONE has no effect.
- Simultaneous abort and class-byte handshake: abort wins; the byte is consumed and no write occurs.
- Simultaneous load_start and abort in IDLE: load_start wins.
- Reset mid-load returns immediately to the reset values above. The BRAM contents are not touched.
- Address never wraps. The loader stops after exactly DEPTH writes.
- Engine interlock, at top level: engine start is gated by loaded && !busy.

Decomposition:
- Shared package knn_pkg holds:
  - DEPTH, ADDR_W, DATA_W;
  - field positions X_MSB=17, X_LSB=10, Y_MSB=9, Y_LSB=2, CLS_BIT=1, VLD_BIT=0;
  - the loader state enum.
- The distance engine uses the same field constants for unpacking.
- No sub-module: packing is a single concatenation and the FSM is small. The block is one module.

Test Plan:
- Reset with reset=0 mid-stream (state GET_Y) -> all outputs 0 in the same cycle, with no clock needed; in_ready=0.
- load_start, then bytes 0x05,0xFB,0x01 with in_valid held high -> one cycle after the third accept: wr_en=1, wr_addr=0, wr_data=18'h017EF (x=5, y=-5, class=1, valid=1); samples_written=1.
- Full load of 64 samples with x=i, y=-i, class=i[0] and continuous valid -> 64 wr_en pulses at addresses 0..63, exactly 4 cycles apart. load_done pulses once, in the cycle after the write to addr 63. loaded=1, busy=0, samples_written=64.
- in_valid toggled 1/0 randomly during a load -> identical BRAM image to the continuous case; no byte lost or duplicated; in_ready=0 during WRITE.
- Class byte 0x03 -> class bit=1 written and fmt_err=1; fmt_err persists through the load and clears on the next load_start.
- abort asserted in the same cycle as the 10th sample's class byte -> no write at addr 9; IDLE next cycle; samples_written=9, loaded=0. A load_start 2 cycles later restarts at wr_addr=0.
